// File: rtl/animation_datapath.sv
// Coin-travel and step-progress-bar animation datapath driving a pixel-plot VGA adapter.
// Optional macro ANIM_ERASE_EN: erase the coin before each move (otherwise the coin leaves a trail).
module animation_datapath #(
    parameter int unsigned FRAME_DIV   = 833333,
    parameter logic [2:0]  COIN_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] travel,
    input  logic [1:0] step,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done_travel,
    output logic       done_step
);

    localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [3:0] {
        Idle, Draw, WaitTick, Erase, Move, BarCol, BarWait, Done, WaitClr
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] frame_q;
    logic          tick;
    logic [7:0]    cx_q, cx_d, dest_q, dest_d;
    logic [6:0]    cy_q, cy_d;
    logic [3:0]    off_q, off_d;
    logic [4:0]    col_q, col_d;
    logic [1:0]    n_q, n_d;
    logic          job_travel_q, job_travel_d;
    logic [7:0]    x_d;
    logic [6:0]    y_d;
    logic [2:0]    colour_d;
    logic          plot_d;
    logic [7:0]    path_start, path_dest, bar_base;

    // Free-running; requests never realign the frame tick.
    assign tick = (frame_q == CW'(FRAME_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)   frame_q <= '0;
        else if (tick) frame_q <= '0;
        else           frame_q <= frame_q + 1'b1;
    end

    always_comb begin
        path_start = 8'd10;
        path_dest  = 8'd80;
        unique case (travel)
            3'd2:    begin path_start = 8'd80;  path_dest = 8'd150; end
            3'd3:    begin path_start = 8'd10;  path_dest = 8'd150; end
            3'd4:    begin path_start = 8'd80;  path_dest = 8'd10;  end
            3'd5:    begin path_start = 8'd150; path_dest = 8'd80;  end
            3'd6:    begin path_start = 8'd150; path_dest = 8'd10;  end
            default: begin path_start = 8'd10;  path_dest = 8'd80;  end
        endcase
    end

    always_comb begin
        unique case (n_q)
            2'd2:    bar_base = 8'd60;
            2'd3:    bar_base = 8'd100;
            default: bar_base = 8'd20;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        dest_d       = dest_q;
        off_d        = off_q;
        col_d        = col_q;
        n_d          = n_q;
        job_travel_d = job_travel_q;
        x_d          = x;
        y_d          = y;
        colour_d     = colour;
        plot_d       = 1'b0;
        unique case (state_q)
            Idle: begin
                if (travel != 3'd0 && travel != 3'd7) begin
                    cx_d         = path_start;
                    cy_d         = 7'd60;
                    dest_d       = path_dest;
                    off_d        = 4'd0;
                    job_travel_d = 1'b1;
                    state_d      = Draw;
                end else if (step != 2'd0) begin
                    n_d          = step;
                    col_d        = 5'd0;
                    off_d        = 4'd0;
                    job_travel_d = 1'b0;
                    state_d      = BarCol;
                end
            end
            Draw, Erase: begin
                plot_d   = 1'b1;
                colour_d = (state_q == Draw) ? COIN_COLOUR : BG_COLOUR;
                x_d      = cx_q + {6'd0, off_q[1:0]};
                y_d      = cy_q + {5'd0, off_q[3:2]};
                off_d    = off_q + 4'd1;
                if (off_q == 4'd15) state_d = (state_q == Draw) ? WaitTick : Move;
            end
            WaitTick: begin
                if (cx_q == dest_q) begin
                    state_d = Done;
                end else if (tick) begin
`ifdef ANIM_ERASE_EN
                    state_d = Erase;
`else
                    state_d = Move;
`endif
                end
            end
            Move: begin
                cx_d    = (dest_q > cx_q) ? cx_q + 8'd1 : cx_q - 8'd1;
                state_d = Draw;
            end
            BarCol: begin
                plot_d   = 1'b1;
                colour_d = {1'b0, n_q};
                x_d      = bar_base + {3'd0, col_q};
                y_d      = 7'd100 + {5'd0, off_q[1:0]};
                off_d    = off_q + 4'd1;
                if (off_q[1:0] == 2'd3) begin
                    off_d   = 4'd0;
                    state_d = BarWait;
                end
            end
            BarWait: begin
                if (col_q == 5'd31) begin
                    state_d = Done;
                end else if (tick) begin
                    col_d   = col_q + 5'd1;
                    state_d = BarCol;
                end
            end
            Done: state_d = WaitClr;
            WaitClr: begin
                if (job_travel_q ? (travel == 3'd0) : (step == 2'd0)) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= Idle;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            dest_q       <= 8'd0;
            off_q        <= 4'd0;
            col_q        <= 5'd0;
            n_q          <= 2'd0;
            job_travel_q <= 1'b0;
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            plot         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            dest_q       <= dest_d;
            off_q        <= off_d;
            col_q        <= col_d;
            n_q          <= n_d;
            job_travel_q <= job_travel_d;
            x            <= x_d;
            y            <= y_d;
            colour       <= colour_d;
            plot         <= plot_d;
        end
    end

    assign done_travel = (state_q == Done) && job_travel_q;
    assign done_step   = (state_q == Done) && !job_travel_q;

endmodule

// File: tb/tb_animation_datapath.sv
// Scoreboard bench for animation_datapath (default build, coin leaves a trail, FRAME_DIV=4).
module tb_animation_datapath;

    logic       clock;
    logic       resetn;
    logic [2:0] travel;
    logic [1:0] step;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done_travel;
    logic       done_step;

    int checks   = 0;
    int failures = 0;
    int dt_cnt   = 0;
    int ds_cnt   = 0;
    int plot_cnt = 0;
    logic [17:0] exp_q[$];

    animation_datapath #(
        .FRAME_DIV  (4),
        .COIN_COLOUR(3'b110),
        .BG_COLOUR  (3'b000)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .travel     (travel),
        .step       (step),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done_travel(done_travel),
        .done_step  (done_step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] pix(input int px, input int py, input int c);
        logic [7:0] xv;
        logic [6:0] yv;
        logic [2:0] cv;
        xv = px[7:0];
        yv = py[6:0];
        cv = c[2:0];
        return {xv, yv, cv};
    endfunction

    task automatic push_travel(input int sx, input int dx);
        int p;
        p = sx;
        forever begin
            for (int off = 0; off < 16; off++)
                exp_q.push_back(pix(p + off % 4, 60 + off / 4, 6));
            if (p == dx) break;
            p += (dx > sx) ? 1 : -1;
        end
    endtask

    task automatic push_bar(input int n);
        for (int col = 0; col < 32; col++)
            for (int r = 0; r < 4; r++)
                exp_q.push_back(pix(20 + 40 * (n - 1) + col, 100 + r, n));
    endtask

    task automatic wait_dt(input int target, input int budget);
        int n = 0;
        while (dt_cnt < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(dt_cnt, target, "done_travel_count");
    endtask

    task automatic wait_ds(input int target, input int budget);
        int n = 0;
        while (ds_cnt < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(ds_cnt, target, "done_step_count");
    endtask

    // Every plotted pixel must match the next expected pixel in order.
    always @(negedge clock) begin
        if (resetn) begin
            if (done_travel) dt_cnt++;
            if (done_step) ds_cnt++;
            if (plot) begin
                plot_cnt++;
                if (exp_q.size() == 0) begin
                    check({14'd0, x, y, colour}, 32'hFFFF_FFFF, "unexpected_plot");
                end else begin
                    check({14'd0, x, y, colour}, {14'd0, exp_q.pop_front()}, "pixel");
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        travel = 3'd0;
        step   = 2'd0;
        repeat (3) @(negedge clock);
        check(plot, 0, "reset_plot");
        check(x, 0, "reset_x");
        check(y, 0, "reset_y");
        check(colour, 0, "reset_colour");
        check(done_travel, 0, "reset_done_travel");
        check(done_step, 0, "reset_done_step");
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        check(plot, 0, "idle_plot");

        // A->B with code held: one job, 71 positions, then silence.
        plot_cnt = 0;
        push_travel(10, 80);
        travel = 3'd1;
        @(posedge clock); #1;
        check(plot, 0, "latency_cycle1");
        @(posedge clock); #1;
        check(plot, 1, "latency_cycle2");
        check(x, 10, "first_x");
        check(y, 60, "first_y");
        wait_dt(1, 3000);
        repeat (200) @(negedge clock);
        check(dt_cnt, 1, "held_travel_no_restart");
        check(plot_cnt, 71 * 16, "travel1_plot_count");
        check(exp_q.size(), 0, "travel1_queue_empty");
        travel = 3'd0;
        repeat (5) @(negedge clock);

        // C->A, decrementing.
        push_travel(150, 10);
        travel = 3'd6;
        wait_dt(2, 5000);
        check(exp_q.size(), 0, "travel6_queue_empty");
        travel = 3'd0;
        repeat (5) @(negedge clock);

        // Step 2 progress bar.
        plot_cnt = 0;
        push_bar(2);
        step = 2'd2;
        wait_ds(1, 1000);
        check(plot_cnt, 128, "bar2_plot_count");
        check(exp_q.size(), 0, "bar2_queue_empty");
        step = 2'd0;
        repeat (5) @(negedge clock);

        // Travel wins over step; step runs only after travel clears.
        push_travel(10, 150);
        push_bar(1);
        travel = 3'd3;
        step   = 2'd1;
        wait_dt(3, 5000);
        repeat (20) @(negedge clock);
        check(ds_cnt, 1, "step_deferred");
        check(exp_q.size(), 128, "bar1_pending");
        travel = 3'd0;
        wait_ds(2, 1000);
        check(exp_q.size(), 0, "bar1_queue_empty");
        step = 2'd0;
        repeat (5) @(negedge clock);

        // Reset in the middle of DRAW.
        push_travel(10, 80);
        travel = 3'd1;
        repeat (6) @(posedge clock);
        #1;
        check(plot, 1, "mid_draw_plot");
        resetn = 1'b0;
        #1;
        check(plot, 0, "reset_async_plot");
        check(done_travel, 0, "reset_async_done_travel");
        exp_q.delete();
        travel = 3'd0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        check(dt_cnt, 3, "no_done_after_reset");
        push_bar(3);
        step = 2'd3;
        wait_ds(3, 1000);
        check(exp_q.size(), 0, "bar3_after_reset");
        step = 2'd0;
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
